// File: rtl/ahb_lite_master_if.sv
//==============================================================================
// ahb_lite_master_if
// Command/response stream and AHB-Lite master bus bundled for ahb_lite_master.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface ahb_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic [1:0]        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_master.sv
//==============================================================================
// ahb_lite_master
// Valid/ready command stream to single NONSEQ AHB-Lite transfers, with ERROR replay.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ahb_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic          HCLK,
  input  wire logic          HRESET,
  ahb_lite_master_if.master  bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase stage
  logic              a_valid_q, a_valid_d;
  logic              a_hold_q,  a_hold_d;
  logic              a_write_q, a_write_d;
  logic [ADDR_W-1:0] a_addr_q,  a_addr_d;
  logic [2:0]        a_size_q,  a_size_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  // Data-phase stage
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  // Response registers
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic err1;
  logic a_issue;
  logic a_advance;
  logic d_done;
  logic cmd_ready;
  logic cmd_accept;

  always_comb begin
    err1       = d_valid_q & ~bus.HREADY & (bus.HRESP != 2'b00);
    a_issue    = a_valid_q & ~a_hold_q;
    a_advance  = a_issue & bus.HREADY;
    d_done     = d_valid_q & bus.HREADY;
    cmd_ready  = ~HRESET & (~a_valid_q | (bus.HREADY & ~a_hold_q & ~err1));
    cmd_accept = bus.cmd_valid & cmd_ready;
  end

  always_comb begin
    a_valid_d   = a_valid_q;
    a_hold_d    = a_hold_q;
    a_write_d   = a_write_q;
    a_addr_d    = a_addr_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;

    // The data stage is only refilled at an edge where the bus accepts an address.
    if (bus.HREADY) begin
      d_valid_d = a_advance;
      if (a_advance) begin
        d_write_d = a_write_q;
        d_wdata_d = a_wdata_q;
      end
    end

    if (a_advance) begin
      a_valid_d = 1'b0;
    end
    if (cmd_accept) begin
      a_valid_d = 1'b1;
      a_write_d = bus.cmd_write;
      a_addr_d  = bus.cmd_addr;
      a_size_d  = bus.cmd_size;
      a_wdata_d = bus.cmd_wdata;
    end

    // First ERROR cycle cancels the pending address; second cycle releases it for replay.
    if (err1 & a_valid_q) begin
      a_hold_d = 1'b1;
    end else if (a_hold_q & bus.HREADY) begin
      a_hold_d = 1'b0;
    end

    rsp_valid_d = d_done;
    rsp_rdata_d = (d_done & ~d_write_q) ? bus.HRDATA : '0;
    rsp_error_d = d_done & (bus.HRESP != 2'b00);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_hold_q    <= 1'b0;
      a_write_q   <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= 3'd0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_hold_q    <= a_hold_d;
      a_write_q   <= a_write_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.HTRANS    = a_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_addr_q;
  assign bus.HWRITE    = a_write_q;
  assign bus.HSIZE     = a_size_q;
  assign bus.HWDATA    = d_wdata_q;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
//==============================================================================
// tb_ahb_lite_master
// Scoreboard bench: behavioural AHB slave, reference response model, directed + random.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ahb_lite_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  ahb_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial forever #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  exp_t exp_q[$];
  int   lat_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  int fixed_waits = 0;

  // slave data-phase state and end-of-cycle snapshot of the bus
  bit          dp_valid = 1'b0;
  logic [31:0] dp_addr = '0;
  bit          dp_write = 1'b0;
  bit          dp_err = 1'b0;
  int          dp_waits = 0;
  int          dp_errstage = 0;
  logic [1:0]  s_trans = 2'b00;
  logic [31:0] s_addr = '0;
  logic        s_write = 1'b0;
  logic [2:0]  s_size = 3'd0;
  logic        s_ready = 1'b1;
  logic        s_rst = 1'b1;

  function automatic bit unmapped(input logic [31:0] a);
    return a[31];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge HCLK) cyc <= cyc + 1;

  // Behavioural slave: unmapped upper half answers with a two-cycle ERROR.
  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    bus.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (s_rst) begin
        dp_valid = 1'b0;
      end else if (s_ready) begin
        dp_valid = (s_trans == 2'b10);
        if (dp_valid) begin
          dp_addr     = s_addr;
          dp_write    = s_write;
          dp_err      = unmapped(s_addr);
          dp_waits    = (fixed_waits < 0) ? int'($urandom_range(0, 2)) : fixed_waits;
          dp_errstage = 0;
        end
      end
      bus.HREADY = 1'b1;
      bus.HRESP  = 2'b00;
      bus.HRDATA = $urandom;
      if (dp_valid) begin
        if (dp_waits > 0) begin
          bus.HREADY = 1'b0;
          dp_waits--;
        end else if (dp_err) begin
          bus.HRESP   = 2'b01;
          bus.HRDATA  = '0;
          bus.HREADY  = (dp_errstage == 1);
          dp_errstage++;
        end else if (!dp_write) begin
          bus.HRDATA = slv_mem.exists(dp_addr) ? slv_mem[dp_addr] : dp_addr;
        end
      end
      #4;
      if (dp_valid && bus.HREADY && dp_write && !dp_err) slv_mem[dp_addr] = bus.HWDATA;
      s_trans = bus.HTRANS;
      s_addr  = bus.HADDR;
      s_write = bus.HWRITE;
      s_size  = bus.HSIZE;
      s_ready = bus.HREADY;
      s_rst   = HRESET;
    end
  end

  // Monitor: bus legality and in-order response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      #3;
      chk("htrans_legal", 32'(bus.HTRANS == 2'b00 || bus.HTRANS == 2'b10), 32'd1);
      if (!s_rst && !s_ready && s_trans == 2'b10) begin
        chk("haddr_stable", bus.HADDR, s_addr);
        chk("ctrl_stable", {bus.HWRITE, bus.HSIZE}, {s_write, s_size});
      end
      if (bus.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 required no pending response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
          lat_q.push_back(cyc - e.acc_cyc);
        end
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
  task automatic send(input bit w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    exp_t e;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #2;
      if (bus.cmd_ready === 1'b1) begin
        e.err     = unmapped(a);
        e.rdata   = (w || e.err) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : a);
        e.acc_cyc = cyc + 1;
        if (w && !e.err) ref_mem[a] = d;
        exp_q.push_back(e);
        #8;
        bus.cmd_valid = 1'b0;
        return;
      end
      #8;
    end
    n_checks++;
    n_fail++;
    $display("FAIL cmd_accept_timeout: got cmd_ready=0 for 200 cycles required acceptance");
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) #10;
    chk("drain_pending", exp_q.size(), 0);
    #20;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = 3'd0;
    bus.cmd_wdata = '0;
    @(negedge HCLK);
    #1;
    #30;
    #2;
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_hwrite_hsize", {bus.HWRITE, bus.HSIZE}, 0);
    chk("rst_hwdata", bus.HWDATA, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_error}, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("const_ctrl", {bus.HBURST, bus.HPROT, bus.HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
    #8;
    HRESET = 1'b0;
    #2;
    chk("cmd_ready_release", bus.cmd_ready, 1);
    #10;
    chk("cmd_ready_after_release", bus.cmd_ready, 1);
    #8;

    // single zero-wait write
    fixed_waits = 0;
    lat_q.delete();
    send(1'b1, 32'h100, 3'd2, 32'h1234_5678);
    #2;
    chk("wr_htrans", bus.HTRANS, 2'b10);
    chk("wr_haddr", bus.HADDR, 32'h100);
    chk("wr_hwrite_hsize", {bus.HWRITE, bus.HSIZE}, {1'b1, 3'd2});
    #10;
    chk("wr_hwdata", bus.HWDATA, 32'h1234_5678);
    #10;
    chk("wr_rsp", {bus.rsp_valid, bus.rsp_error}, 2'b10);
    #8;
    drain();

    // four back-to-back reads
    lat_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'(4 * i);
      bus.cmd_size  = 3'd2;
      bus.cmd_valid = 1'b1;
      #2;
      chk("b2b_ready", bus.cmd_ready, 1);
      if (bus.cmd_ready === 1'b1) begin
        exp_q.push_back('{rdata: 32'(4 * i), err: 1'b0, acc_cyc: cyc + 1});
      end
      if (i > 0) chk("b2b_nonseq", {bus.HTRANS, bus.HADDR}, {2'b10, 32'(4 * (i - 1))});
      #8;
    end
    bus.cmd_valid = 1'b0;
    #2;
    chk("b2b_nonseq", {bus.HTRANS, bus.HADDR}, {2'b10, 32'hC});
    #8;
    drain();
    chk("b2b_rsp_count", lat_q.size(), 4);
    foreach (lat_q[i]) chk("b2b_latency", lat_q[i], 2);

    // wait states
    lat_q.delete();
    fixed_waits = 3;
    send(1'b0, 32'h20, 3'd2, 32'h0);
    send(1'b0, 32'h24, 3'd2, 32'h0);
    bus.cmd_addr  = 32'h28;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("wait_cmd_ready", bus.cmd_ready, 0);
      chk("wait_addr_held", {bus.HTRANS, bus.HADDR}, {2'b10, 32'h24});
      #8;
    end
    send(1'b0, 32'h28, 3'd2, 32'h0);
    drain();
    if (lat_q.size() > 0) chk("wait_latency", lat_q[0], 5);
    else chk("wait_rsp_count", lat_q.size(), 3);
    fixed_waits = 0;

    // ERROR with a read waiting in the address phase
    send(1'b1, 32'h8000_0000, 3'd2, 32'hCAFE_F00D);
    send(1'b0, 32'h40, 3'd2, 32'h0);
    #2;
    chk("err_c1_nonseq", {bus.HTRANS, bus.HADDR}, {2'b10, 32'h40});
    #10;
    chk("err_c2_idle", {bus.HTRANS, bus.HADDR}, {2'b00, 32'h40});
    #10;
    chk("err_replay", {bus.HTRANS, bus.HADDR}, {2'b10, 32'h40});
    chk("err_rsp", {bus.rsp_valid, bus.rsp_error}, 2'b11);
    #8;
    drain();

    // reset during a waited data phase
    fixed_waits = 3;
    send(1'b0, 32'h44, 3'd2, 32'hFFFF_FFFF);
    #10;
    HRESET = 1'b1;
    exp_q.delete();
    #10;
    HRESET = 1'b0;
    #2;
    chk("mid_rst_bus", {bus.HTRANS, bus.HWRITE, bus.HSIZE}, 0);
    chk("mid_rst_haddr", bus.HADDR, 0);
    chk("mid_rst_hwdata", bus.HWDATA, 0);
    chk("mid_rst_rsp", {bus.rsp_valid, bus.rsp_error}, 0);
    chk("mid_rst_rdata", bus.rsp_rdata, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    for (int k = 0; k < 5; k++) begin
      #10;
      chk("mid_rst_no_rsp", bus.rsp_valid, 0);
    end
    #8;

    // randomized traffic
    fixed_waits = -1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        #10;
      end else begin
        bit          w;
        logic [2:0]  s;
        logic [31:0] a;
        w = 1'($urandom_range(0, 1));
        s = 3'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 15) * 4) | (32'($urandom_range(0, 3)) & ~((32'd1 << s) - 32'd1));
        if ($urandom_range(0, 4) == 0) a = a | 32'h8000_0000;
        send(w, a, s, $urandom);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
